npu_op_sequencer: RTL and testbench

//  Host-side initiator for the NPU START/DONE protocol. Queues operand sets and issues each to the NPU core with a single-cycle START.

---
 rtl/npu_pkg.sv | 25 ++
 rtl/npu_op_fifo.sv | 54 +++++
 rtl/npu_op_sequencer.sv | 122 ++++++++++++
 tb/tb_npu_op_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and field layout for the NPU operand sequencer.
// Queue word layout is {SSFR[55:40], BIAS, DD, DC, DB, DA}.
package npu_pkg;

  localparam int OP_W     = 40;
  localparam int QW       = 56;
  localparam int DA_LSB   = 0;
  localparam int DB_LSB   = 8;
  localparam int DC_LSB   = 16;
  localparam int DD_LSB   = 24;
  localparam int BIAS_LSB = 32;
  localparam int SSFR_LSB = 40;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_CAPTURE   = 2'd3
  } state_t;

  function automatic logic [7:0] field8(input logic [QW-1:0] word, input int lsb);
    return word[lsb +: 8];
  endfunction

endpackage

// File: rtl/npu_op_fifo.sv
// Synchronous FIFO with first-word-fall-through head; holds queued operand sets.
// Pushes while full and pops while empty are ignored.
module npu_op_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 56
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; an entry is always written before the count exposes it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/npu_op_sequencer.sv
// Host-side START/DONE initiator: queues operand sets, issues one at a time to the
// NPU core, captures the result and returns it over a valid/ready port.
module npu_op_sequencer import npu_pkg::*; #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clkext,
  input  logic                   rst_glo,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [OP_W-1:0]        op_data,
  input  logic [15:0]            op_ssfr,
  output logic                   npu_start,
  output logic [7:0]             npu_da,
  output logic [7:0]             npu_db,
  output logic [7:0]             npu_dc,
  output logic [7:0]             npu_dd,
  output logic [7:0]             npu_bias,
  output logic [15:0]            npu_ssfr,
  input  logic                   npu_busy,
  input  logic                   npu_done,
  input  logic [7:0]             npu_dout,
  input  logic                   npu_fifo_full,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [7:0]             res_data,
  output logic                   err_timeout,
  input  logic                   err_clr,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [QW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          timeout_hit;
  logic          issue_ok;

  assign op_ready    = !fifo_full;
  assign push        = op_valid && op_ready;
  // DONE has priority over an expiring timer in the same cycle.
  assign timeout_hit = (state == S_WAIT_DONE) && !npu_done && (timer == TIMER_LAST);
  assign pop         = timeout_hit || ((state == S_CAPTURE) && res_valid && res_ready);
  assign issue_ok    = (state == S_IDLE) && !fifo_empty && !npu_busy && !npu_fifo_full && !res_valid;

  npu_op_fifo #(.DEPTH(DEPTH), .W(QW)) u_fifo (
    .clk   (clkext),
    .rst_n (rst_glo),
    .push  (push),
    .pop   (pop),
    .din   ({op_ssfr, op_data}),
    .dout  (head),
    .count (pending),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clkext) begin
    if (!rst_glo) begin
      state       <= S_IDLE;
      timer       <= '0;
      npu_start   <= 1'b0;
      npu_da      <= '0;
      npu_db      <= '0;
      npu_dc      <= '0;
      npu_dd      <= '0;
      npu_bias    <= '0;
      npu_ssfr    <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (timeout_hit)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;

      case (state)
        S_IDLE: begin
          if (issue_ok) begin
            npu_da    <= field8(head, DA_LSB);
            npu_db    <= field8(head, DB_LSB);
            npu_dc    <= field8(head, DC_LSB);
            npu_dd    <= field8(head, DD_LSB);
            npu_bias  <= field8(head, BIAS_LSB);
            npu_ssfr  <= head[SSFR_LSB +: 16];
            npu_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          npu_start <= 1'b0;
          timer     <= '0;
          state     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          timer <= timer + 1'b1;
          if (npu_done) begin
            res_data  <= npu_dout;
            res_valid <= 1'b1;
            state     <= S_CAPTURE;
          end else if (timer == TIMER_LAST) begin
            state <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_op_sequencer.sv
// Scoreboard bench for npu_op_sequencer: a behavioural NPU core answers START,
// expected results are queued at push time and compared on each result handshake.
module tb_npu_op_sequencer;

  logic        clkext = 1'b0;
  logic        rst_glo;
  logic        op_valid;
  logic        op_ready;
  logic [39:0] op_data;
  logic [15:0] op_ssfr;
  logic        npu_start;
  logic [7:0]  npu_da, npu_db, npu_dc, npu_dd, npu_bias;
  logic [15:0] npu_ssfr;
  logic        npu_busy;
  logic        npu_done;
  logic [7:0]  npu_dout;
  logic        npu_fifo_full;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        err_timeout;
  logic        err_clr;
  logic [3:0]  pending;

  always #5 clkext = ~clkext;

  npu_op_sequencer dut (
    .clkext        (clkext),
    .rst_glo       (rst_glo),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_data       (op_data),
    .op_ssfr       (op_ssfr),
    .npu_start     (npu_start),
    .npu_da        (npu_da),
    .npu_db        (npu_db),
    .npu_dc        (npu_dc),
    .npu_dd        (npu_dd),
    .npu_bias      (npu_bias),
    .npu_ssfr      (npu_ssfr),
    .npu_busy      (npu_busy),
    .npu_done      (npu_done),
    .npu_dout      (npu_dout),
    .npu_fifo_full (npu_fifo_full),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .err_timeout   (err_timeout),
    .err_clr       (err_clr),
    .pending       (pending)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  bit         model_en     = 1'b0;
  int         model_delay  = 4;
  int         late_done_req = 0;

  // Behavioural core: DA*DB + DC*DD + 5*BIAS, modulo 256.
  function automatic logic [7:0] core_fn(input logic [39:0] d);
    logic [7:0] da, db, dc, dd, bias;
    {bias, dd, dc, db, da} = d;
    return da * db + dc * dd + 8'd5 * bias;
  endfunction

  function automatic logic [39:0] mk_op(input logic [7:0] da, db, dc, dd, bias);
    return {bias, dd, dc, db, da};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clkext);
    #1;
  endtask

  task automatic push_op(input logic [39:0] d, input logic [15:0] s, input bit want);
    int w = 0;
    op_data  = d;
    op_ssfr  = s;
    op_valid = 1'b1;
    while (!op_ready && w < 300) begin
      tick();
      w++;
    end
    if (!op_ready) check("push_ready_timeout", 32'(op_ready), 1);
    tick();
    op_valid = 1'b0;
    if (want) exp_q.push_back(core_fn(d));
  endtask

  task automatic drain(input string name);
    int w = 0;
    while ((pending != 0 || res_valid) && w < 2000) begin
      tick();
      w++;
    end
    check(name, 32'(pending), 0);
    repeat (3) tick();
  endtask

  task automatic wait_start(input string name);
    int w = 0;
    while (!npu_start && w < 40) begin
      tick();
      w++;
    end
    check(name, 32'(npu_start), 1);
  endtask

  // NPU core model: inputs driven on the falling edge, stable across the rising edge.
  initial begin
    int served = 0;
    logic [7:0] d;
    npu_done = 1'b0;
    npu_dout = '0;
    forever begin
      @(negedge clkext);
      if (late_done_req != served) begin
        served++;
        npu_done = 1'b1;
        npu_dout = 8'h5A;
        @(negedge clkext);
        npu_done = 1'b0;
      end else if (npu_start && model_en) begin
        d = core_fn({npu_bias, npu_dd, npu_dc, npu_db, npu_da});
        repeat (model_delay) @(negedge clkext);
        npu_done = 1'b1;
        npu_dout = d;
        @(negedge clkext);
        npu_done = 1'b0;
        npu_dout = '0;
      end
    end
  end

  // Result monitor: every handshake pops one expected value.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clkext);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got %0h expected none", res_data);
        end else begin
          e = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [39:0] fill_ops [8];
  int          starts;

  initial begin
    fill_ops[0] = mk_op(8'd1,  8'd2,  8'd3,  8'd4,  8'd0);
    fill_ops[1] = mk_op(8'd10, 8'd10, 8'd0,  8'd0,  8'd1);
    fill_ops[2] = mk_op(8'd0,  8'd9,  8'd7,  8'd7,  8'd2);
    fill_ops[3] = mk_op(8'hFF, 8'd2,  8'd1,  8'd1,  8'd3);
    fill_ops[4] = mk_op(8'd16, 8'd16, 8'd5,  8'd6,  8'd4);
    fill_ops[5] = mk_op(8'd7,  8'd0,  8'd0,  8'd9,  8'd50);
    fill_ops[6] = mk_op(8'd12, 8'd11, 8'd3,  8'd13, 8'd6);
    fill_ops[7] = mk_op(8'd2,  8'd3,  8'd5,  8'd7,  8'd11);

    rst_glo = 1'b0; op_valid = 1'b0; op_data = '0; op_ssfr = '0;
    npu_busy = 1'b0; npu_fifo_full = 1'b0; res_ready = 1'b0; err_clr = 1'b0;

    // Power-on reset
    tick(); tick();
    check("rst_start", 32'(npu_start), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_pending", 32'(pending), 0);
    rst_glo = 1'b1;
    tick();
    check("rst_op_ready", 32'(op_ready), 1);

    // Single op: START on the 2nd cycle after accept, DONE after 4 cycles
    model_en = 1'b1; model_delay = 4;
    push_op(mk_op(8'd3, 8'd4, 8'd2, 8'd5, 8'd1), 16'hBEEF, 1'b1);
    check("start_cycle1", 32'(npu_start), 0);
    tick();
    check("start_cycle2", 32'(npu_start), 1);
    check("npu_da", 32'(npu_da), 3);
    check("npu_db", 32'(npu_db), 4);
    check("npu_dc", 32'(npu_dc), 2);
    check("npu_dd", 32'(npu_dd), 5);
    check("npu_bias", 32'(npu_bias), 1);
    check("npu_ssfr", 32'(npu_ssfr), 32'hBEEF);
    tick();
    check("start_width", 32'(npu_start), 0);
    repeat (3) tick();
    check("res_valid_early", 32'(res_valid), 0);
    tick();
    check("res_valid_rise", 32'(res_valid), 1);
    check("res_data_27", 32'(res_data), 27);
    repeat (3) tick();
    check("res_valid_held", 32'(res_valid), 1);
    check("res_data_held", 32'(res_data), 27);
    check("operands_stable", 32'({npu_da, npu_db, npu_dc, npu_dd}), 32'h03040205);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_fall", 32'(res_valid), 0);
    check("single_pending", 32'(pending), 0);

    // Reset mid-traffic; the model's late DONE must be ignored
    model_delay = 12;
    push_op(mk_op(8'd9, 8'd9, 8'd9, 8'd9, 8'd9), 16'h1234, 1'b0);
    push_op(mk_op(8'd8, 8'd8, 8'd8, 8'd8, 8'd8), 16'h5678, 1'b0);
    repeat (4) tick();
    rst_glo = 1'b0;
    tick(); tick();
    check("mid_rst_start", 32'(npu_start), 0);
    check("mid_rst_operands", 32'({npu_da, npu_db, npu_dc, npu_dd}), 0);
    check("mid_rst_bias_ssfr", 32'({npu_bias, npu_ssfr}), 0);
    check("mid_rst_res", 32'({res_valid, res_data}), 0);
    check("mid_rst_pending", 32'(pending), 0);
    rst_glo = 1'b1;
    tick();
    check("mid_rst_op_ready", 32'(op_ready), 1);
    repeat (15) tick();
    check("stale_done_ignored", 32'(res_valid), 0);

    // Fill the queue while the core is busy, then drain in order
    npu_busy = 1'b1; res_ready = 1'b1; model_delay = 2;
    for (int i = 0; i < 8; i++) push_op(fill_ops[i], 16'(16'h1000 + i), 1'b1);
    check("fill_pending", 32'(pending), 8);
    check("fill_op_ready", 32'(op_ready), 0);
    op_valid = 1'b1;
    op_data  = mk_op(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
    repeat (3) tick();
    check("ninth_not_taken", 32'(pending), 8);
    op_valid = 1'b0;
    npu_busy = 1'b0;
    drain("fill_drain");
    check("fill_all_results", 32'(exp_q.size()), 0);

    // Core output FIFO full blocks issue; unconsumed result blocks the next issue
    npu_fifo_full = 1'b1; res_ready = 1'b0;
    push_op(mk_op(8'd6, 8'd7, 8'd1, 8'd2, 8'd3), 16'h00A1, 1'b1);
    starts = 0;
    repeat (50) begin
      tick();
      if (npu_start) starts++;
    end
    check("fifo_full_blocks", starts, 0);
    check("fifo_full_pending", 32'(pending), 1);
    npu_fifo_full = 1'b0;
    tick();
    check("start_after_unblock", 32'(npu_start), 1);
    push_op(mk_op(8'd4, 8'd4, 8'd4, 8'd4, 8'd4), 16'h00A2, 1'b1);
    starts = 0;
    repeat (20) begin
      tick();
      if (npu_start) starts++;
    end
    check("no_issue_while_res_held", starts, 0);
    check("held_res_valid", 32'(res_valid), 1);
    check("held_pending", 32'(pending), 2);
    res_ready = 1'b1;
    drain("backpressure_drain");

    // Timeout: first op never answered, second one must issue afterwards
    model_en = 1'b0;
    push_op(mk_op(8'd1, 8'd1, 8'd1, 8'd1, 8'd1), 16'h0DEA, 1'b0);
    push_op(mk_op(8'd5, 8'd6, 8'd7, 8'd8, 8'd9), 16'h0B0B, 1'b1);
    wait_start("timeout_op_start");
    tick();
    model_en = 1'b1; model_delay = 3;
    repeat (254) tick();
    check("err_before_timeout", 32'(err_timeout), 0);
    check("pending_before_timeout", 32'(pending), 2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_at_timeout", 32'(err_timeout), 1);
    check("pending_after_timeout", 32'(pending), 1);
    check("no_result_on_timeout", 32'(res_valid), 0);
    tick();
    check("next_issue_after_timeout", 32'(npu_start), 1);
    drain("timeout_drain");
    check("err_sticky", 32'(err_timeout), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 32'(err_timeout), 0);

    // Reset during WAIT_DONE followed by a late DONE
    model_en = 1'b0;
    push_op(mk_op(8'd2, 8'd2, 8'd2, 8'd2, 8'd2), 16'h0C0C, 1'b0);
    wait_start("late_done_op_start");
    repeat (5) tick();
    rst_glo = 1'b0;
    tick(); tick();
    rst_glo = 1'b1;
    late_done_req++;
    repeat (4) tick();
    check("late_done_res_valid", 32'(res_valid), 0);
    check("late_done_pending", 32'(pending), 0);
    check("late_done_start", 32'(npu_start), 0);
    model_en = 1'b1;
    push_op(mk_op(8'd3, 8'd3, 8'd3, 8'd3, 8'd3), 16'h0D0D, 1'b1);
    check("idle_after_reset_c1", 32'(npu_start), 0);
    tick();
    check("idle_after_reset_c2", 32'(npu_start), 1);
    drain("final_drain");

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
